// File: rtl/seq_serializer_if.sv
// Handshake and serial-output bundle for seq_serializer.
// The master side presents words and observes the serial stream;
// the slave side is the serializer itself.
interface seq_serializer_if #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16
);

  logic [DATA_W-1:0] i_data;
  logic              i_valid;
  logic              o_ready;
  logic [DIV_W-1:0]  i_div;
  logic              i_lsb_first;
  logic              o_seq;
  logic              o_seq_valid;
  logic              o_busy;
  logic              o_done;

  modport master (
    output i_data, i_valid, i_div, i_lsb_first,
    input  o_ready, o_seq, o_seq_valid, o_busy, o_done
  );

  modport slave (
    input  i_data, i_valid, i_div, i_lsb_first,
    output o_ready, o_seq, o_seq_valid, o_busy, o_done
  );

endinterface

// File: rtl/seq_serializer.sv
// Parallel-to-serial bit source for the serial pattern detectors.
// A DATA_W-bit word is accepted over valid/ready, then shifted out one
// bit per (div+1) clock cycles, MSB- or LSB-first. A one-cycle done
// pulse follows the last bit period, after which the next word may be
// accepted. All outputs are registered.
module seq_serializer #(
  parameter int   DATA_W     = 8,
  parameter int   DIV_W      = 16,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input logic            clk,
  input logic            rst,
  seq_serializer_if.slave bus
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state;

  // Word storage: the bit currently on o_seq has already been removed,
  // so the next bit to send always sits at the outgoing end.
  logic [DATA_W-1:0] shreg;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic              lsb_q;

  // Registered outputs
  logic              ready_q;
  logic              seq_q;
  logic              seq_valid_q;
  logic              busy_q;
  logic              done_q;

  // Derived bit-selection values
  logic              first_bit;
  logic [DATA_W-1:0] load_rest;
  logic              next_bit;
  logic [DATA_W-1:0] shreg_shifted;

  assign first_bit     = bus.i_lsb_first ? bus.i_data[0] : bus.i_data[DATA_W-1];
  assign load_rest     = bus.i_lsb_first ? (bus.i_data >> 1) : (bus.i_data << 1);
  assign next_bit      = lsb_q ? shreg[0] : shreg[DATA_W-1];
  assign shreg_shifted = lsb_q ? (shreg >> 1) : (shreg << 1);

  // Control FSM with all outputs and datapath registers updated together
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: every register here uses <= so all updates see pre-edge values;
    // a blocking = would let later statements read the freshly written value.
    if (!rst) begin
      state       <= S_IDLE;
      shreg       <= '0;
      div_q       <= '0;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      lsb_q       <= 1'b0;
      ready_q     <= 1'b0;
      seq_q       <= IDLE_LEVEL;
      seq_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.i_valid && ready_q) begin
            // Accept: capture the word and its options, drive the first bit
            shreg       <= load_rest;
            div_q       <= bus.i_div;
            lsb_q       <= bus.i_lsb_first;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b1;
            seq_q       <= first_bit;
            seq_valid_q <= 1'b1;
            done_q      <= 1'b0;
            state       <= S_SHIFT;
          end else begin
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            seq_q       <= IDLE_LEVEL;
            seq_valid_q <= 1'b0;
            done_q      <= 1'b0;
          end
        end

        S_SHIFT: begin
          if (div_cnt == div_q) begin
            div_cnt <= '0;
            if (bit_cnt == LAST_BIT) begin
              seq_q       <= IDLE_LEVEL;
              seq_valid_q <= 1'b0;
              done_q      <= 1'b1;
              state       <= S_DONE;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
              seq_q   <= next_bit;
              shreg   <= shreg_shifted;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state   <= S_IDLE;
        end

        default: begin
          // NOTE: the unused encoding recovers to idle with reset-valued
          // outputs, so a corrupted state register cannot stall the block.
          state       <= S_IDLE;
          ready_q     <= 1'b0;
          seq_q       <= IDLE_LEVEL;
          seq_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_ready     = ready_q;
  assign bus.o_seq       = seq_q;
  assign bus.o_seq_valid = seq_valid_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_done      = done_q;

endmodule

// File: tb/tb_seq_serializer.sv
// Self-checking bench for seq_serializer: vector table of words with
// their expected serial streams, a bit scoreboard fed at stimulus time
// and drained by a monitor, plus hand sequences for back-to-back
// handshake, mid-word reset and a chained 01 detector.
module tb_seq_serializer;

  localparam int DATA_W = 8;
  localparam int DIV_W  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_serializer_if #(.DATA_W(DATA_W), .DIV_W(DIV_W)) bus ();

  seq_serializer #(
    .DATA_W    (DATA_W),
    .DIV_W     (DIV_W),
    .IDLE_LEVEL(1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard of expected serial bits, one entry per clock cycle of o_seq_valid
  logic exp_q[$];
  int   cyc       = 0;
  int   done_seen = 0;
  int   det_cnt   = 0;
  logic det_prev  = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: sample away from the active edge, drain scoreboard, run a 01 detector
  always @(negedge clk) begin
    if (bus.o_done) done_seen <= done_seen + 1;
    if (bus.o_seq_valid) begin
      if (exp_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
      else check("sb_bit", {31'd0, bus.o_seq}, {31'd0, exp_q.pop_front()});
      if (!det_prev && bus.o_seq) det_cnt <= det_cnt + 1;
      det_prev <= bus.o_seq;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] data;
    logic [3:0] div;
    logic       lsb;
    logic [7:0] stream;  // bit 7 is the first bit expected on o_seq
  } vec_t;

  vec_t vecs[7];

  // Push each stream bit (div+1) times, first bit first
  task automatic push_stream(input logic [7:0] stream, input logic [3:0] div);
    for (int b = DATA_W - 1; b >= 0; b--)
      repeat (int'(div) + 1) exp_q.push_back(stream[b]);
  endtask

  // Called at a negedge with i_valid already asserted
  task automatic wait_ready(input string tag);
    for (int k = 0; k < 300; k++) begin
      if (bus.o_ready) return;
      @(negedge clk);
    end
    check({tag, " ready_timeout"}, 32'd0, 32'd1);
  endtask

  // One complete word with timing checks; entered and left at a negedge
  task automatic run_word(input logic [7:0] data, input logic [3:0] div, input logic lsb,
                          input logic [7:0] stream, input string tag);
    int n;
    int vcnt;
    n    = DATA_W * (int'(div) + 1);
    vcnt = 0;
    bus.i_data      = data;
    bus.i_div       = div;
    bus.i_lsb_first = lsb;
    bus.i_valid     = 1'b1;
    wait_ready(tag);
    push_stream(stream, div);
    @(posedge clk);
    @(negedge clk);
    // Cycle 1: drop valid and scramble inputs, which must be ignored
    bus.i_valid     = 1'b0;
    bus.i_data      = ~data;
    bus.i_div       = ~div;
    bus.i_lsb_first = ~lsb;
    for (int c = 1; c <= n; c++) begin
      if (c > 1) @(negedge clk);
      if (bus.o_seq_valid && bus.o_busy && !bus.o_done && !bus.o_ready) vcnt++;
    end
    check({tag, " valid_cycles"}, vcnt, n);
    @(negedge clk);
    check({tag, " done_pulse"}, {31'd0, bus.o_done}, 32'd1);
    check({tag, " done_valid"}, {31'd0, bus.o_seq_valid}, 32'd0);
    check({tag, " done_busy"}, {31'd0, bus.o_busy}, 32'd1);
    check({tag, " done_ready"}, {31'd0, bus.o_ready}, 32'd0);
    check({tag, " done_idle_level"}, {31'd0, bus.o_seq}, 32'd1);
    @(negedge clk);
    check({tag, " ready_back"}, {31'd0, bus.o_ready}, 32'd1);
    check({tag, " done_cleared"}, {31'd0, bus.o_done}, 32'd0);
    check({tag, " busy_cleared"}, {31'd0, bus.o_busy}, 32'd0);
    check({tag, " sb_empty"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    int t0;
    int k_done;
    int d0;
    int det0;
    logic found;

    vecs[0] = '{data: 8'hA5, div: 4'd0,  lsb: 1'b0, stream: 8'hA5};
    vecs[1] = '{data: 8'h01, div: 4'd3,  lsb: 1'b1, stream: 8'h80};
    vecs[2] = '{data: 8'hC3, div: 4'd1,  lsb: 1'b0, stream: 8'hC3};
    vecs[3] = '{data: 8'h35, div: 4'd0,  lsb: 1'b1, stream: 8'hAC};
    vecs[4] = '{data: 8'h96, div: 4'd2,  lsb: 1'b1, stream: 8'h69};
    vecs[5] = '{data: 8'h5A, div: 4'hF,  lsb: 1'b0, stream: 8'h5A};
    vecs[6] = '{data: 8'h0F, div: 4'd0,  lsb: 1'b1, stream: 8'hF0};

    rst             = 1'b0;
    bus.i_valid     = 1'b0;
    bus.i_data      = '0;
    bus.i_div       = '0;
    bus.i_lsb_first = 1'b0;

    // Reset values, held across several edges
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, bus.o_ready}, 32'd0);
    check("rst_seq", {31'd0, bus.o_seq}, 32'd1);
    check("rst_seq_valid", {31'd0, bus.o_seq_valid}, 32'd0);
    check("rst_busy", {31'd0, bus.o_busy}, 32'd0);
    check("rst_done", {31'd0, bus.o_done}, 32'd0);
    rst = 1'b1;
    #1;
    check("ready_before_edge", {31'd0, bus.o_ready}, 32'd0);
    @(negedge clk);
    check("ready_after_edge", {31'd0, bus.o_ready}, 32'd1);

    // Table-driven words
    for (int i = 0; i < 7; i++)
      run_word(vecs[i].data, vecs[i].div, vecs[i].lsb, vecs[i].stream, $sformatf("vec%0d", i));

    // Back-to-back: valid held, second word presented right after first accept
    bus.i_data      = 8'hF0;
    bus.i_div       = 4'd0;
    bus.i_lsb_first = 1'b0;
    bus.i_valid     = 1'b1;
    wait_ready("b2b_first");
    t0 = cyc;
    push_stream(8'hF0, 4'd0);
    @(posedge clk);
    @(negedge clk);
    bus.i_data = 8'h0F;
    bus.i_div  = 4'd7;
    push_stream(8'h0F, 4'd0);
    found = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      if (k == 4) bus.i_div = 4'd0;
      if (bus.o_ready) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("b2b_second_ready", {31'd0, found}, 32'd1);
    check("b2b_accept_gap", cyc - t0, 32'd10);
    @(posedge clk);
    @(negedge clk);
    bus.i_valid = 1'b0;
    bus.i_data  = 8'h00;
    k_done = 0;
    for (int k = 1; k <= 20; k++) begin
      k_done = k;
      if (bus.o_done) break;
      @(negedge clk);
    end
    check("b2b_done_cycle", k_done, 32'd9);
    @(negedge clk);
    check("b2b_ready_back", {31'd0, bus.o_ready}, 32'd1);
    check("b2b_sb_empty", exp_q.size(), 32'd0);

    // Reset in the middle of the 4th bit
    bus.i_data      = 8'hFF;
    bus.i_div       = 4'd2;
    bus.i_lsb_first = 1'b0;
    bus.i_valid     = 1'b1;
    wait_ready("mid_rst");
    push_stream(8'hFF, 4'd2);
    @(posedge clk);
    @(negedge clk);
    bus.i_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_rst_active", {31'd0, bus.o_seq_valid}, 32'd1);
    d0 = done_seen;
    #2;
    rst = 1'b0;
    #1;
    exp_q.delete();
    check("mid_rst_ready", {31'd0, bus.o_ready}, 32'd0);
    check("mid_rst_seq", {31'd0, bus.o_seq}, 32'd1);
    check("mid_rst_seq_valid", {31'd0, bus.o_seq_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, bus.o_busy}, 32'd0);
    check("mid_rst_done", {31'd0, bus.o_done}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_ready_after", {31'd0, bus.o_ready}, 32'd1);
    @(negedge clk);
    check("mid_rst_no_done", done_seen - d0, 32'd0);
    run_word(8'h80, 4'd0, 1'b0, 8'h80, "after_rst");

    // Chained 01 detector on 00110101 MSB-first
    det0 = det_cnt;
    run_word(8'h35, 4'd0, 1'b0, 8'h35, "det");
    @(negedge clk);
    check("det_pulses", det_cnt - det0, 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
